// File: rtl/uart_reg_ctrl.sv
// Host register port for the UART: divisor/enable config, TX push, RX pop, status with sticky overrun.
// Latency: register/TX ops respond 1 cycle after accept; DATA read responds 3 cycles after accept.
// Backpressure: one outstanding request; req_ready low from accept until the response is taken.
module uart_reg_ctrl #(
  parameter int          D_W     = 8,
  parameter int          DIV_W   = 16,
  parameter int unsigned DIV_RST = 54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [3:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             fifo_tx_wr_en,
  output logic [D_W-1:0]   fifo_tx_data_in,
  input  logic             fifo_tx_full,
  input  logic             fifo_tx_empty,
  output logic             fifo_rx_rd_en,
  input  logic [D_W-1:0]   fifo_rx_data_out,
  input  logic             fifo_rx_full,
  input  logic             fifo_rx_empty,
  input  logic             rx_drop,
  output logic [DIV_W-1:0] divxr,
  output logic             tx_en,
  output logic             rx_en
);

  typedef enum logic [1:0] {S_IDLE, S_POP, S_CAPT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_tx_wr_en;
  logic [D_W-1:0]     r_tx_data;
  logic [DIV_W-1:0]   r_divxr;
  logic               r_tx_en;
  logic               r_rx_en;
  logic               r_rx_ovr;

  logic [31:0]        w_rdata_nxt;
  logic               w_err_nxt;
  logic               w_push;
  logic               w_div_wr;
  logic               w_ctrl_wr;
  logic               w_ovr_clr;
  logic               w_addr_ok;
  logic [31:0]        w_status;
  logic [31:0]        w_ctrl_rd;
  logic               w_unused;

  // Upper write-data bits beyond the widest register are deliberately ignored.
  assign w_unused  = ^req_wdata[31:DIV_W];

  assign w_status  = {27'd0, r_rx_ovr, fifo_tx_full, fifo_tx_empty, fifo_rx_full, fifo_rx_empty};
  assign w_ctrl_rd = {30'd0, r_rx_en, r_tx_en};
  assign w_addr_ok = (req_addr[1:0] == 2'b00);

  assign req_ready       = (r_state == S_IDLE);
  assign rsp_valid       = (r_state == S_RESP);
  assign fifo_rx_rd_en   = (r_state == S_POP);
  assign rsp_rdata       = r_rsp_rdata;
  assign rsp_err         = r_rsp_err;
  assign fifo_tx_wr_en   = r_tx_wr_en;
  assign fifo_tx_data_in = r_tx_data;
  assign divxr           = r_divxr;
  assign tx_en           = r_tx_en;
  assign rx_en           = r_rx_en;

  // State register; reset drops any pending transaction and its strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Request decode, next-state and response data selection.
  always_comb begin
    w_state_nxt = r_state;
    w_rdata_nxt = r_rsp_rdata;
    w_err_nxt   = r_rsp_err;
    w_push      = 1'b0;
    w_div_wr    = 1'b0;
    w_ctrl_wr   = 1'b0;
    w_ovr_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
          if (!w_addr_ok) begin
            w_err_nxt = 1'b1;
          end else begin
            case (req_addr[3:2])
              2'd0: begin
                if (req_write) begin
                  if (fifo_tx_full) w_err_nxt = 1'b1;
                  else              w_push    = 1'b1;
                end else if (fifo_rx_empty) begin
                  w_err_nxt = 1'b1;
                end else begin
                  w_state_nxt = S_POP;
                end
              end
              2'd1: begin
                if (req_write) w_err_nxt   = 1'b1;
                else           w_rdata_nxt = w_status;
              end
              2'd2: begin
                if (req_write) begin
                  if (req_wdata[DIV_W-1:0] == '0) w_err_nxt = 1'b1;
                  else                            w_div_wr  = 1'b1;
                end else begin
                  w_rdata_nxt = 32'(r_divxr);
                end
              end
              default: begin
                if (req_write) begin
                  w_ctrl_wr = 1'b1;
                  w_ovr_clr = req_wdata[4];
                end else begin
                  w_rdata_nxt = w_ctrl_rd;
                end
              end
            endcase
          end
        end
      end
      S_POP:  w_state_nxt = S_CAPT;
      S_CAPT: begin
        // RX FIFO data is valid the cycle after the pop strobe.
        w_state_nxt = S_RESP;
        w_rdata_nxt = 32'(fifo_rx_data_out);
      end
      S_RESP: if (rsp_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Response payload; held unchanged while the response waits for rsp_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_rdata <= w_rdata_nxt;
      r_rsp_err   <= w_err_nxt;
    end
  end

  // Single-cycle TX push strobe with its data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr_en <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_wr_en <= w_push;
      if (w_push) r_tx_data <= req_wdata[D_W-1:0];
    end
  end

  // Divisor and enable configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_divxr <= DIV_W'(DIV_RST);
      r_tx_en <= 1'b0;
      r_rx_en <= 1'b0;
    end else begin
      if (w_div_wr) r_divxr <= req_wdata[DIV_W-1:0];
      if (w_ctrl_wr) begin
        r_tx_en <= req_wdata[0];
        r_rx_en <= req_wdata[1];
      end
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_rx_ovr <= 1'b0;
    else if (rx_drop)   r_rx_ovr <= 1'b1;
    else if (w_ovr_clr) r_rx_ovr <= 1'b0;
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Directed bench for uart_reg_ctrl with a one-word RX FIFO read model.
// Requests are driven on the falling edge; outputs are sampled on the falling edge.
// Response backpressure is exercised by holding rsp_ready low.
module tb_uart_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [3:0]  req_addr = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        fifo_tx_wr_en;
  logic [7:0]  fifo_tx_data_in;
  logic        fifo_tx_full = 1'b0;
  logic        fifo_tx_empty = 1'b1;
  logic        fifo_rx_rd_en;
  logic [7:0]  fifo_rx_data_out = 8'h00;
  logic        fifo_rx_full = 1'b0;
  logic        fifo_rx_empty = 1'b1;
  logic        rx_drop = 1'b0;
  logic [15:0] divxr;
  logic        tx_en;
  logic        rx_en;

  logic [7:0]  rx_word = 8'h00;

  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] x_rdata;
  logic        x_err;
  int          x_lat;
  int          x_push;
  int          x_pop;
  logic [7:0]  x_pdata;

  uart_reg_ctrl #(.D_W(8), .DIV_W(16), .DIV_RST(54)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .rsp_err          (rsp_err),
    .fifo_tx_wr_en    (fifo_tx_wr_en),
    .fifo_tx_data_in  (fifo_tx_data_in),
    .fifo_tx_full     (fifo_tx_full),
    .fifo_tx_empty    (fifo_tx_empty),
    .fifo_rx_rd_en    (fifo_rx_rd_en),
    .fifo_rx_data_out (fifo_rx_data_out),
    .fifo_rx_full     (fifo_rx_full),
    .fifo_rx_empty    (fifo_rx_empty),
    .rx_drop          (rx_drop),
    .divxr            (divxr),
    .tx_en            (tx_en),
    .rx_en            (rx_en)
  );

  always #5 clk = ~clk;

  // RX FIFO read port: word appears the cycle after the pop strobe.
  always @(posedge clk) fifo_rx_data_out <= fifo_rx_rd_en ? rx_word : 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One request with rsp_ready high; records latency, strobes and response.
  task automatic xact(input logic w, input logic [3:0] a, input logic [31:0] d, input logic drop);
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; rx_drop = drop;
    x_lat = 0; x_push = 0; x_pop = 0; x_pdata = 8'h00;
    do begin
      @(negedge clk);
      req_valid = 1'b0; rx_drop = 1'b0;
      x_lat++;
      x_push += int'(fifo_tx_wr_en);
      x_pop  += int'(fifo_rx_rd_en);
      if (fifo_tx_wr_en) x_pdata = fifo_tx_data_in;
    end while (!rsp_valid && x_lat < 20);
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    x_rdata = rsp_rdata;
    x_err   = rsp_err;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      x_push += int'(fifo_tx_wr_en);
      x_pop  += int'(fifo_rx_rd_en);
    end
    chk("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata_err", {rsp_rdata[30:0], rsp_err}, 32'd0);
    chk("rst_strobes", {30'd0, fifo_tx_wr_en, fifo_rx_rd_en}, 32'd0);
    chk("rst_tx_data", {24'd0, fifo_tx_data_in}, 32'd0);
    chk("rst_divxr", {16'd0, divxr}, 32'd54);
    chk("rst_en", {30'd0, rx_en, tx_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset register values via reads
    xact(1'b0, 4'h8, 32'h0, 1'b0);
    chk("rd_div_rst", x_rdata, 32'd54);
    chk("rd_div_rst_err", {31'd0, x_err}, 32'd0);
    chk("rd_div_lat", x_lat, 32'd1);
    xact(1'b0, 4'hC, 32'h0, 1'b0);
    chk("rd_ctrl_rst", x_rdata, 32'd0);

    // Divisor writes, including zero-valued and upper-bit-ignored cases
    xact(1'b1, 4'h8, 32'h0000_0036, 1'b0);
    chk("wr_div_err", {31'd0, x_err}, 32'd0);
    chk("wr_div_val", {16'd0, divxr}, 32'h36);
    xact(1'b1, 4'h8, 32'hFFFF_0000, 1'b0);
    chk("wr_div0_err", {31'd0, x_err}, 32'd1);
    chk("wr_div0_keep", {16'd0, divxr}, 32'h36);
    xact(1'b0, 4'h8, 32'h0, 1'b0);
    chk("rd_div_36", x_rdata, 32'h36);
    xact(1'b1, 4'h8, 32'h1234_00A0, 1'b0);
    chk("wr_div_hi_ign", {16'd0, divxr}, 32'hA0);

    // CTRL enables
    xact(1'b1, 4'hC, 32'h3, 1'b0);
    chk("ctrl_en", {30'd0, rx_en, tx_en}, 32'd3);
    xact(1'b0, 4'hC, 32'h0, 1'b0);
    chk("rd_ctrl_3", x_rdata, 32'd3);

    // TX push: accepted, then refused when full
    xact(1'b1, 4'h0, 32'h0000_01A5, 1'b0);
    chk("tx_push_cnt", x_push, 32'd1);
    chk("tx_push_dat", {24'd0, x_pdata}, 32'hA5);
    chk("tx_push_err", {31'd0, x_err}, 32'd0);
    fifo_tx_full = 1'b1;
    xact(1'b1, 4'h0, 32'h0000_005A, 1'b0);
    chk("tx_full_cnt", x_push, 32'd0);
    chk("tx_full_err", {31'd0, x_err}, 32'd1);
    chk("tx_full_rdata", x_rdata, 32'd0);

    // RX pop: word present, then empty
    rx_word = 8'h3C; fifo_rx_empty = 1'b0;
    xact(1'b0, 4'h0, 32'h0, 1'b0);
    chk("rx_pop_cnt", x_pop, 32'd1);
    chk("rx_pop_lat", x_lat, 32'd3);
    chk("rx_pop_dat", x_rdata, 32'h3C);
    chk("rx_pop_err", {31'd0, x_err}, 32'd0);
    fifo_rx_empty = 1'b1;
    xact(1'b0, 4'h0, 32'h0, 1'b0);
    chk("rx_empty_cnt", x_pop, 32'd0);
    chk("rx_empty_lat", x_lat, 32'd1);
    chk("rx_empty_dat", x_rdata, 32'd0);
    chk("rx_empty_err", {31'd0, x_err}, 32'd1);

    // STATUS flags and sticky overrun
    fifo_rx_empty = 1'b1; fifo_rx_full = 1'b0; fifo_tx_empty = 1'b0; fifo_tx_full = 1'b1;
    xact(1'b0, 4'h4, 32'h0, 1'b0);
    chk("status_09", x_rdata, 32'h09);
    @(negedge clk); rx_drop = 1'b1;
    @(negedge clk); rx_drop = 1'b0;
    fifo_rx_empty = 1'b0; fifo_rx_full = 1'b1; fifo_tx_empty = 1'b1; fifo_tx_full = 1'b0;
    xact(1'b0, 4'h4, 32'h0, 1'b0);
    chk("status_ovr", x_rdata, 32'h16);
    xact(1'b1, 4'hC, 32'h10, 1'b1);
    chk("ovr_clr_coinc_err", {31'd0, x_err}, 32'd0);
    xact(1'b0, 4'h4, 32'h0, 1'b0);
    chk("ovr_set_wins", x_rdata, 32'h16);
    xact(1'b1, 4'hC, 32'h10, 1'b0);
    xact(1'b0, 4'h4, 32'h0, 1'b0);
    chk("ovr_cleared", x_rdata, 32'h06);
    xact(1'b0, 4'hC, 32'h0, 1'b0);
    chk("ctrl_bit4_rd0", x_rdata, 32'd0);

    // Error addresses
    xact(1'b0, 4'h5, 32'h0, 1'b0);
    chk("misalign_rd_err", {31'd0, x_err}, 32'd1);
    chk("misalign_rd_dat", x_rdata, 32'd0);
    xact(1'b1, 4'h4, 32'hFF, 1'b0);
    chk("wr_status_err", {31'd0, x_err}, 32'd1);
    xact(1'b1, 4'h9, 32'h77, 1'b0);
    chk("misalign_wr_err", {31'd0, x_err}, 32'd1);
    chk("misalign_wr_div", {16'd0, divxr}, 32'hA0);

    // Response held under backpressure
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h8;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hA0);
      chk("bp_err", {31'd0, rsp_err}, 32'd0);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);

    // Reset asserted while popping
    xact(1'b1, 4'hC, 32'h3, 1'b0);
    fifo_rx_empty = 1'b0; rx_word = 8'h55;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pop_before_rst", {31'd0, fifo_rx_rd_en}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", {31'd0, fifo_rx_rd_en}, 32'd0);
    chk("mid_rst_ready", {30'd0, req_ready, rsp_valid}, 32'd2);
    chk("mid_rst_rsp", {rsp_rdata[30:0], rsp_err}, 32'd0);
    chk("mid_rst_tx", {23'd0, fifo_tx_wr_en, fifo_tx_data_in}, 32'd0);
    chk("mid_rst_div", {16'd0, divxr}, 32'd54);
    chk("mid_rst_en", {30'd0, rx_en, tx_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 4'h4, 32'h0, 1'b0);
    chk("post_rst_status", x_rdata, 32'h06);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
